wb_arbiter: RTL and testbench

WB_ARBITER -- requirements
Module: wb_arbiter

---
 rtl/wb_arb_pkg.sv | 12 +
 rtl/if_wb.sv | 17 +
 rtl/wb_arbiter.sv | 120 ++++++++++++
 tb/tb_wb_arbiter.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/wb_arb_pkg.sv
// Shared types and defaults for the two-requester Wishbone arbiter.
package wb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } arb_state_t;

  localparam int unsigned MAX_OUT_DEFAULT = 7;

endpackage

// File: rtl/if_wb.sv
// Pipelined Wishbone bundle; master drives the request, slave drives the response.
interface if_wb #(
  parameter int unsigned AW = 16,
  parameter int unsigned DW = 16
);
  logic          cyc;
  logic          stb;
  logic          we;
  logic [AW-1:0] adr;
  logic [DW-1:0] dat_m;
  logic          stall;
  logic          ack;
  logic [DW-1:0] dat_s;

  modport master (output cyc, stb, we, adr, dat_m, input stall, ack, dat_s);
  modport slave  (input cyc, stb, we, adr, dat_m, output stall, ack, dat_s);
endinterface

// File: rtl/wb_arbiter.sv
// Round-robin arbiter granting one of two Wishbone requesters the shared bus,
// with an outstanding-transfer limit and discard of acks left over from aborts.
module wb_arbiter
  import wb_arb_pkg::*;
#(
  parameter int unsigned AW      = 16,
  parameter int unsigned DW      = 16,
  parameter int unsigned MAX_OUT = MAX_OUT_DEFAULT
) (
  input logic clk,
  input logic rst_n,
  if_wb.slave  m0,
  if_wb.slave  m1,
  if_wb.master s
);
  localparam int unsigned       CNT_W    = $clog2(MAX_OUT + 1);
  localparam int unsigned       DROP_W   = CNT_W + 2;
  localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(MAX_OUT);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [DROP_W-1:0] DROP_ONE = DROP_W'(1);

  arb_state_t        state;
  logic              last_grant;
  logic [CNT_W-1:0]  out_cnt, out_next;
  logic [DROP_W-1:0] drop_cnt, drop_base;
  logic [DROP_W:0]   drop_sum;
  logic              granted, full, acc, ack_live, ack_drop, release_gnt;
  logic              sel_cyc, sel_stb, sel_we;
  logic [AW-1:0]     sel_adr;
  logic [DW-1:0]     sel_dat;

  always_comb begin
    sel_cyc     = (state == GNT1) ? m1.cyc   : m0.cyc;
    sel_stb     = (state == GNT1) ? m1.stb   : m0.stb;
    sel_we      = (state == GNT1) ? m1.we    : m0.we;
    sel_adr     = (state == GNT1) ? m1.adr   : m0.adr;
    sel_dat     = (state == GNT1) ? m1.dat_m : m0.dat_m;
    granted     = (state != IDLE);
    full        = (out_cnt == CNT_MAX);
    acc         = granted & sel_stb & ~full & ~s.stall;
    // Acks owed to an aborted grant arrive first (in order) and are swallowed.
    ack_drop    = s.ack & (drop_cnt != '0);
    ack_live    = s.ack & (drop_cnt == '0) & (out_cnt != '0);
    release_gnt = granted & ~sel_cyc;
    out_next    = out_cnt;
    if (acc && !ack_live)      out_next = out_cnt + CNT_ONE;
    else if (!acc && ack_live) out_next = out_cnt - CNT_ONE;
    drop_base   = ack_drop ? drop_cnt - DROP_ONE : drop_cnt;
    drop_sum    = {1'b0, drop_base} + {{(DROP_W + 1 - CNT_W){1'b0}}, out_next};
  end

  always_comb begin
    s.cyc   = granted & sel_cyc;
    s.stb   = granted & sel_stb & ~full;
    s.we    = granted & sel_we;
    s.adr   = granted ? sel_adr : '0;
    s.dat_m = granted ? sel_dat : '0;
    m0.stall = 1'b1;
    m0.ack   = 1'b0;
    m0.dat_s = '0;
    m1.stall = 1'b1;
    m1.ack   = 1'b0;
    m1.dat_s = '0;
    case (state)
      GNT0: begin
        m0.stall = s.stall | full;
        m0.ack   = s.ack & (drop_cnt == '0);
        m0.dat_s = s.dat_s;
      end
      GNT1: begin
        m1.stall = s.stall | full;
        m1.ack   = s.ack & (drop_cnt == '0);
        m1.dat_s = s.dat_s;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_cnt  <= '0;
      drop_cnt <= '0;
    end else if (release_gnt) begin
      out_cnt  <= '0;
      drop_cnt <= drop_sum[DROP_W] ? '1 : drop_sum[DROP_W-1:0];
    end else begin
      out_cnt  <= out_next;
      drop_cnt <= drop_base;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (m0.cyc && m1.cyc) state <= last_grant ? GNT0 : GNT1;
          else if (m0.cyc)      state <= GNT0;
          else if (m1.cyc)      state <= GNT1;
        end
        GNT0: begin
          if (!m0.cyc) begin
            last_grant <= 1'b0;
            state      <= m1.cyc ? GNT1 : IDLE;
          end
        end
        GNT1: begin
          if (!m1.cyc) begin
            last_grant <= 1'b1;
            state      <= m0.cyc ? GNT0 : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed scenarios plus random traffic against a transaction-level model.
module tb_wb_arbiter;
  localparam int MAXO = 7;

  logic        clk, rst_n;
  logic        c[2], st[2], wem[2];
  logic [15:0] adr_a[2], dm_a[2];
  logic        sstall, sack;
  logic [15:0] sdat;
  int          vec = 0, bad = 0;

  if_wb #(.AW(16), .DW(16)) m0_if ();
  if_wb #(.AW(16), .DW(16)) m1_if ();
  if_wb #(.AW(16), .DW(16)) s_if ();

  wb_arbiter #(.AW(16), .DW(16), .MAX_OUT(MAXO)) dut (
    .clk(clk), .rst_n(rst_n), .m0(m0_if), .m1(m1_if), .s(s_if)
  );

  assign m0_if.cyc = c[0];      assign m1_if.cyc = c[1];
  assign m0_if.stb = st[0];     assign m1_if.stb = st[1];
  assign m0_if.we  = wem[0];    assign m1_if.we  = wem[1];
  assign m0_if.adr = adr_a[0];  assign m1_if.adr = adr_a[1];
  assign m0_if.dat_m = dm_a[0]; assign m1_if.dat_m = dm_a[1];
  assign s_if.stall = sstall;
  assign s_if.ack   = sack;
  assign s_if.dat_s = sdat;

  logic [1:0]  stall_o, ack_o;
  logic [15:0] dats_o[2];
  assign stall_o   = {m1_if.stall, m0_if.stall};
  assign ack_o     = {m1_if.ack, m0_if.ack};
  assign dats_o[0] = m0_if.dat_s;
  assign dats_o[1] = m1_if.dat_s;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: grant owner (-1 none), last owner, and the slave's in-order queue of
  // accepted transfers tagged with the grant session that issued them.
  int g = -1, last = 1, sess = 0;
  int pend[$];

  always @(negedge clk) begin
    int live, o;
    logic full, fwd, acc;
    acc = 1'b0;
    if (!rst_n) begin
      g = -1; last = 1; sess++; pend.delete();
      check("rst_s_cyc", s_if.cyc, 0);
      check("rst_s_stb", s_if.stb, 0);
      check("rst_stall", stall_o, 2'b11);
      check("rst_ack", ack_o, 2'b00);
    end else begin
      live = 0;
      foreach (pend[k]) if (pend[k] == sess) live++;
      if (g < 0) begin
        check("idle_s_cyc", s_if.cyc, 0);
        check("idle_s_stb", s_if.stb, 0);
        check("idle_stall", stall_o, 2'b11);
        check("idle_ack", ack_o, 2'b00);
        check("idle_dat0", dats_o[0], 0);
        check("idle_dat1", dats_o[1], 0);
      end else begin
        o    = 1 - g;
        full = (live == MAXO);
        fwd  = sack && (pend.size() == 0 || pend[0] == sess);
        check("s_cyc", s_if.cyc, c[g]);
        check("s_stb", s_if.stb, st[g] && !full);
        check("s_we", s_if.we, wem[g]);
        check("s_adr", s_if.adr, adr_a[g]);
        check("s_dat_m", s_if.dat_m, dm_a[g]);
        check($sformatf("m%0d_stall", g), stall_o[g], sstall || full);
        check($sformatf("m%0d_stall", o), stall_o[o], 1);
        check($sformatf("m%0d_ack", g), ack_o[g], fwd);
        check($sformatf("m%0d_ack", o), ack_o[o], 0);
        check($sformatf("m%0d_dat_s", g), dats_o[g], sdat);
        check($sformatf("m%0d_dat_s", o), dats_o[o], 0);
        acc = st[g] && !full && !sstall;
      end
      if (sack && pend.size() > 0) void'(pend.pop_front());
      if (acc) pend.push_back(sess);
      if (g < 0) begin
        if (c[0] && c[1]) g = (last == 1) ? 0 : 1;
        else if (c[0])    g = 0;
        else if (c[1])    g = 1;
      end else if (!c[g]) begin
        last = g;
        sess++;
        g = c[1-g] ? 1 - g : -1;
      end
    end
  end

  task automatic idle_inputs();
    for (int i = 0; i < 2; i++) begin
      c[i] = 0; st[i] = 0; wem[i] = 0; adr_a[i] = '0; dm_a[i] = '0;
    end
    sstall = 0; sack = 0; sdat = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 0;
    idle_inputs();
    tick();
    tick();
    rst_n = 1;
  endtask

  initial begin
    int n;
    rst_n = 0;
    idle_inputs();

    // single read from m0
    do_reset();
    c[0] = 1; st[0] = 1; adr_a[0] = 16'h2000; #1;
    check("t28_idle_stb", s_if.stb, 0);
    check("t28_idle_m0_stall", m0_if.stall, 1);
    tick(); #1;
    check("t28_stb", s_if.stb, 1);
    check("t28_adr", s_if.adr, 16'h2000);
    check("t28_m0_stall", m0_if.stall, 0);
    check("t28_m1_stall", m1_if.stall, 1);
    tick(); st[0] = 0; sack = 1; sdat = 16'hBEEF; #1;
    check("t28_m0_ack", m0_if.ack, 1);
    check("t28_m0_dat", m0_if.dat_s, 16'hBEEF);
    check("t28_m1_stall2", m1_if.stall, 1);
    check("t28_m1_ack", m1_if.ack, 0);
    tick(); sack = 0; c[0] = 0;
    tick(); #1;
    check("t28_back_idle", m0_if.stall, 1);

    // contention right after reset, then hand-over without idle
    do_reset();
    c[0] = 1; c[1] = 1;
    tick(); #1;
    check("t29_m0_gnt", m0_if.stall, 0);
    check("t29_m1_wait", m1_if.stall, 1);
    c[0] = 0;
    tick(); #1;
    check("t29_m1_gnt", m1_if.stall, 0);
    check("t29_cyc", s_if.cyc, 1);

    // outstanding limit and simultaneous accept+ack
    do_reset();
    c[0] = 1; st[0] = 1;
    tick();
    n = 0;
    repeat (9) begin #1; n += int'(s_if.stb); tick(); end
    check("t30_accepted", n, 7);
    check("t30_full_stall", m0_if.stall, 1);
    sack = 1; #1;
    check("t30_full_stb", s_if.stb, 0);
    tick(); sack = 0; #1;
    check("t30_8th_stb", s_if.stb, 1);
    check("t30_8th_stall", m0_if.stall, 0);
    tick(); #1;
    check("t30_refull", m0_if.stall, 1);
    st[0] = 0; sack = 1;
    repeat (4) tick();
    st[0] = 1;
    tick(); sack = 0;
    n = 0;
    repeat (6) begin #1; n += int'(s_if.stb); tick(); end
    check("t31_room_after_3", n, 4);

    // abort with two outstanding, grant passes to m0, stray acks swallowed
    do_reset();
    c[1] = 1; st[1] = 1;
    tick(); tick(); tick();
    c[1] = 0; st[1] = 0; c[0] = 1;
    tick(); sack = 1; #1;
    check("t32_m0_ack_a", m0_if.ack, 0);
    check("t32_m1_ack_a", m1_if.ack, 0);
    check("t32_m0_gnt", m0_if.stall, 0);
    tick(); #1;
    check("t32_m0_ack_b", m0_if.ack, 0);
    check("t32_m1_ack_b", m1_if.ack, 0);
    tick(); sack = 0; st[0] = 1;
    n = 0;
    repeat (9) begin #1; n += int'(s_if.stb); tick(); end
    check("t32_cnt_cleared", n, 7);

    // async reset mid-transfer
    do_reset();
    c[1] = 1; st[1] = 1;
    tick(); repeat (4) tick();
    rst_n = 0; #1;
    check("t33_cyc_drop", s_if.cyc, 0);
    check("t33_stb_drop", s_if.stb, 0);
    idle_inputs();
    tick(); rst_n = 1; c[0] = 1; c[1] = 1;
    tick(); #1;
    check("t33_m0_wins", m0_if.stall, 0);
    check("t33_m1_waits", m1_if.stall, 1);

    // random traffic
    do_reset();
    repeat (4000) begin
      for (int i = 0; i < 2; i++) begin
        if (!c[i]) begin
          c[i] = ($urandom_range(0, 3) == 0);
          st[i] = 0;
        end else if ($urandom_range(0, 15) == 0) begin
          c[i] = 0; st[i] = 0;
        end else begin
          st[i] = 1'($urandom_range(0, 1));
          wem[i] = 1'($urandom_range(0, 1));
          adr_a[i] = 16'($urandom);
          dm_a[i] = 16'($urandom);
        end
      end
      sstall = ($urandom_range(0, 3) == 0);
      sack = (pend.size() > 0) ? ($urandom_range(0, 9) < 4) : ($urandom_range(0, 19) == 0);
      sdat = 16'($urandom);
      tick();
    end
    idle_inputs();
    tick(); tick();
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end
endmodule
